// File: rtl/debug_run_ctrl_if.sv
// Signal bundle between the UART receiver / core status and the fetch stage's
// program-load and run-control inputs.
interface debug_run_ctrl_if;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned STATE_W = 3;

  logic [BYTE_W-1:0]  rx_data;
  logic               rx_valid;
  logic               halt_i;
  logic               loadProgram;
  logic [WORD_W-1:0]  addressInstrucctionProgram;
  logic [WORD_W-1:0]  data_instruction;
  logic               wr_instruction;
  logic               stop_debug;
  logic               load_overflow;
  logic [WORD_W-1:0]  cycle_count;
  logic [STATE_W-1:0] state_o;

  modport master (
    input  rx_data, rx_valid, halt_i,
    output loadProgram, addressInstrucctionProgram, data_instruction,
           wr_instruction, stop_debug, load_overflow, cycle_count, state_o
  );

  modport slave (
    output rx_data, rx_valid, halt_i,
    input  loadProgram, addressInstrucctionProgram, data_instruction,
           wr_instruction, stop_debug, load_overflow, cycle_count, state_o
  );
endinterface

// File: rtl/debug_run_ctrl.sv
// Program-load and run-control sequencer: assembles little-endian words from UART
// bytes, writes them into instruction memory, then gates PC / IF-ID advance.
module debug_run_ctrl #(
  parameter int unsigned MEM_DEPTH = 256,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input logic             clk,
  input logic             rst,
  debug_run_ctrl_if.master bus
);
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned BUF_W  = 24;
  localparam logic [WORD_W-1:0] ADDR_LAST = WORD_W'(MEM_DEPTH - 1);

  localparam logic [BYTE_W-1:0] CMD_LOAD  = 8'h4C;
  localparam logic [BYTE_W-1:0] CMD_RUN   = 8'h43;
  localparam logic [BYTE_W-1:0] CMD_STEP  = 8'h53;
  localparam logic [BYTE_W-1:0] CMD_PAUSE = 8'h50;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    WRITE = 3'd2,
    READY = 3'd3,
    RUN   = 3'd4,
    STEP  = 3'd5,
    DONE  = 3'd6
  } state_t;

  state_t              state;
  logic [1:0]          byteCnt;
  logic [BUF_W-1:0]    wordBuf;
  logic [WORD_W-1:0]   address;
  logic [WORD_W-1:0]   dataWord;
  logic                wrStrobe;
  logic                loadSel;
  logic                stopDbg;
  logic                overflow;
  logic [WORD_W-1:0]   cycles;

  logic cmdLoad, cmdRun, cmdStep, cmdPause;
  assign cmdLoad  = bus.rx_valid && (bus.rx_data == CMD_LOAD);
  assign cmdRun   = bus.rx_valid && (bus.rx_data == CMD_RUN);
  assign cmdStep  = bus.rx_valid && (bus.rx_data == CMD_STEP);
  assign cmdPause = bus.rx_valid && (bus.rx_data == CMD_PAUSE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      byteCnt  <= 2'd0;
      wordBuf  <= '0;
      address  <= '0;
      dataWord <= '0;
      wrStrobe <= 1'b0;
      loadSel  <= 1'b0;
      stopDbg  <= 1'b1;
      overflow <= 1'b0;
      cycles   <= '0;
    end else begin
      wrStrobe <= 1'b0;
      if (!stopDbg) cycles <= cycles + 32'd1;

      case (state)
        IDLE, READY, DONE: begin
          if (cmdLoad) begin
            state    <= LOAD;
            address  <= '0;
            byteCnt  <= 2'd0;
            cycles   <= '0;
            overflow <= 1'b0;
            loadSel  <= 1'b1;
          end else if (state == READY && cmdRun) begin
            state   <= RUN;
            stopDbg <= 1'b0;
          end else if (state == READY && cmdStep) begin
            state   <= STEP;
            stopDbg <= 1'b0;
          end
        end

        // Every byte here is payload; the fourth completes a word and triggers the write.
        LOAD: begin
          if (bus.rx_valid) begin
            if (byteCnt == 2'd3) begin
              dataWord <= {bus.rx_data, wordBuf};
              wrStrobe <= 1'b1;
              byteCnt  <= 2'd0;
              state    <= WRITE;
            end else begin
              wordBuf[{byteCnt, 3'b000} +: BYTE_W] <= bus.rx_data;
              byteCnt <= byteCnt + 2'd1;
            end
          end
        end

        WRITE: begin
          if (dataWord == HALT_WORD || address == ADDR_LAST) begin
            state   <= READY;
            loadSel <= 1'b0;
            if (dataWord != HALT_WORD) overflow <= 1'b1;
          end else begin
            address <= address + 32'd1;
            state   <= LOAD;
            // A byte landing in the write cycle starts the next word.
            if (bus.rx_valid) begin
              wordBuf[BYTE_W-1:0] <= bus.rx_data;
              byteCnt <= 2'd1;
            end
          end
        end

        RUN: begin
          if (bus.halt_i) begin
            state   <= DONE;
            stopDbg <= 1'b1;
          end else if (cmdPause) begin
            state   <= READY;
            stopDbg <= 1'b1;
          end
        end

        STEP: begin
          stopDbg <= 1'b1;
          state   <= bus.halt_i ? DONE : READY;
        end

        default: begin
          state   <= IDLE;
          stopDbg <= 1'b1;
          loadSel <= 1'b0;
        end
      endcase
    end
  end

  assign bus.loadProgram                = loadSel;
  assign bus.addressInstrucctionProgram = address;
  assign bus.data_instruction           = dataWord;
  assign bus.wr_instruction             = wrStrobe;
  assign bus.stop_debug                 = stopDbg;
  assign bus.load_overflow              = overflow;
  assign bus.cycle_count                = cycles;
  assign bus.state_o                    = state;
endmodule

// File: tb/tb_debug_run_ctrl.sv
// Directed bench for debug_run_ctrl: load, step, run-to-halt, pause, overflow and
// reset-abort sequences with hand-computed expectations.
module tb_debug_run_ctrl;
  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] HALT  = 32'hFFFF_FFFF;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  debug_run_ctrl_if bus();

  debug_run_ctrl #(.MEM_DEPTH(DEPTH), .HALT_WORD(HALT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; outputs are checked at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sendByte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
  endtask

  task automatic sendWord(input logic [31:0] w);
    for (int i = 0; i < 4; i++) sendByte(w[8*i +: 8]);
  endtask

  task automatic loadShort();
    sendByte(8'h4C);
    sendWord(32'h2000_0000);
    sendWord(HALT);
    tick();
    checkEq("reload_ready", 32'(bus.state_o), 32'd3);
    checkEq("reload_cycles", bus.cycle_count, 32'd0);
  endtask

  task automatic checkResetValues(input string tag);
    checkEq({tag, "_state"}, 32'(bus.state_o), 32'd0);
    checkEq({tag, "_stop"}, 32'(bus.stop_debug), 32'd1);
    checkEq({tag, "_loadprog"}, 32'(bus.loadProgram), 32'd0);
    checkEq({tag, "_wr"}, 32'(bus.wr_instruction), 32'd0);
    checkEq({tag, "_addr"}, bus.addressInstrucctionProgram, 32'd0);
    checkEq({tag, "_data"}, bus.data_instruction, 32'd0);
    checkEq({tag, "_ovf"}, 32'(bus.load_overflow), 32'd0);
    checkEq({tag, "_cycles"}, bus.cycle_count, 32'd0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    bus.halt_i   = 1'b0;
    tick();
    tick();
    checkResetValues("reset");
    rst = 1'b0;

    // Load two words, back to back, the second being the halt word.
    sendByte(8'h4C);
    checkEq("L_state", 32'(bus.state_o), 32'd1);
    checkEq("L_loadprog", 32'(bus.loadProgram), 32'd1);
    sendWord(32'h2000_0000);
    checkEq("w0_wr", 32'(bus.wr_instruction), 32'd1);
    checkEq("w0_addr", bus.addressInstrucctionProgram, 32'd0);
    checkEq("w0_data", bus.data_instruction, 32'h2000_0000);
    checkEq("w0_state", 32'(bus.state_o), 32'd2);
    sendByte(8'hFF);
    checkEq("w0_wr_drop", 32'(bus.wr_instruction), 32'd0);
    checkEq("w1_addr_inc", bus.addressInstrucctionProgram, 32'd1);
    sendByte(8'hFF);
    sendByte(8'hFF);
    sendByte(8'hFF);
    checkEq("w1_wr", 32'(bus.wr_instruction), 32'd1);
    checkEq("w1_addr", bus.addressInstrucctionProgram, 32'd1);
    checkEq("w1_data", bus.data_instruction, HALT);
    checkEq("w1_loadprog", 32'(bus.loadProgram), 32'd1);
    tick();
    checkEq("load_ready", 32'(bus.state_o), 32'd3);
    checkEq("load_loadprog_low", 32'(bus.loadProgram), 32'd0);
    checkEq("load_wr_low", 32'(bus.wr_instruction), 32'd0);
    checkEq("load_ovf", 32'(bus.load_overflow), 32'd0);
    checkEq("load_stop", 32'(bus.stop_debug), 32'd1);

    // Three spaced single steps.
    for (int i = 0; i < 3; i++) begin
      sendByte(8'h53);
      checkEq("step_open", 32'(bus.stop_debug), 32'd0);
      checkEq("step_state", 32'(bus.state_o), 32'd5);
      tick();
      checkEq("step_close", 32'(bus.stop_debug), 32'd1);
      checkEq("step_ready", 32'(bus.state_o), 32'd3);
      tick();
      tick();
    end
    checkEq("step_cycles", bus.cycle_count, 32'd3);

    // Run for ten cycles, then halt.
    loadShort();
    sendByte(8'h43);
    checkEq("run_open", 32'(bus.stop_debug), 32'd0);
    checkEq("run_state", 32'(bus.state_o), 32'd4);
    for (int i = 0; i < 9; i++) tick();
    checkEq("run_still_open", 32'(bus.stop_debug), 32'd0);
    bus.halt_i = 1'b1;
    tick();
    bus.halt_i = 1'b0;
    checkEq("halt_stop", 32'(bus.stop_debug), 32'd1);
    checkEq("halt_state", 32'(bus.state_o), 32'd6);
    checkEq("halt_cycles", bus.cycle_count, 32'd10);
    sendByte(8'h43);
    checkEq("done_C_dropped", 32'(bus.state_o), 32'd6);
    sendByte(8'h53);
    checkEq("done_S_dropped", 32'(bus.stop_debug), 32'd1);
    checkEq("done_cycles_hold", bus.cycle_count, 32'd10);

    // Pause after five run cycles, then pause colliding with halt.
    loadShort();
    sendByte(8'h43);
    for (int i = 0; i < 4; i++) tick();
    checkEq("pause_pre", 32'(bus.stop_debug), 32'd0);
    sendByte(8'h50);
    checkEq("pause_stop", 32'(bus.stop_debug), 32'd1);
    checkEq("pause_state", 32'(bus.state_o), 32'd3);
    checkEq("pause_cycles", bus.cycle_count, 32'd5);
    sendByte(8'h43);
    bus.halt_i = 1'b1;
    sendByte(8'h50);
    bus.halt_i = 1'b0;
    checkEq("pause_halt_state", 32'(bus.state_o), 32'd6);
    checkEq("pause_halt_stop", 32'(bus.stop_debug), 32'd1);

    // Fill all DEPTH words without a halt word.
    sendByte(8'h4C);
    for (int k = 0; k < 4; k++) begin
      sendWord(32'h1000_0000 + 32'(k));
      checkEq("ovf_wr", 32'(bus.wr_instruction), 32'd1);
      checkEq("ovf_addr", bus.addressInstrucctionProgram, 32'(k));
      checkEq("ovf_data", bus.data_instruction, 32'h1000_0000 + 32'(k));
    end
    tick();
    checkEq("ovf_ready", 32'(bus.state_o), 32'd3);
    checkEq("ovf_flag", 32'(bus.load_overflow), 32'd1);
    checkEq("ovf_loadprog", 32'(bus.loadProgram), 32'd0);
    sendByte(8'h4C);
    checkEq("ovf_cleared", 32'(bus.load_overflow), 32'd0);
    checkEq("ovf_addr_clr", bus.addressInstrucctionProgram, 32'd0);

    // Reset in the middle of a word, then a fresh load.
    sendByte(8'h12);
    sendByte(8'h34);
    rst = 1'b1;
    tick();
    checkResetValues("midrst");
    rst = 1'b0;
    sendByte(8'h4C);
    sendWord(32'hAABB_CCDD);
    checkEq("fresh_wr", 32'(bus.wr_instruction), 32'd1);
    checkEq("fresh_addr", bus.addressInstrucctionProgram, 32'd0);
    checkEq("fresh_data", bus.data_instruction, 32'hAABB_CCDD);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
